ram_arbiter: RTL and testbench
==============================

Name: ram_arbiter

Overview:
- Two-port round-robin arbiter and access sequencer for the 4-word x 8-bit register-cell RAM.
- Lets two requesters (CPU core, loader/DMA) share the single RAM port through a req/ack handshake.
- Generates the RAM word select, read/write strobe and write data, and returns captured read data.
- Sits between the requesters and the RAM; the RAM is never driven directly by a requester.

Parameters:
- DATA_W, 8, RAM word width.
- ADDR_W, 2, RAM address width (4 words).
- RD_LAT, 1, cycles ram_sel must be held before ram_rdata is captured (1..3).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- req0  in  1  requester 0 access request, held until ack0.
- we0  in  1  requester 0: 1 = write, 0 = read.
- addr0  in  ADDR_W  requester 0 word address.
- wdata0  in  DATA_W  requester 0 write data.
- ack0  out  1  one-cycle completion pulse to requester 0.
- req1, we1, addr1, wdata1, ack1: same as above, for requester 1.
- rdata  out  DATA_W  read data; valid while ack0/ack1 high, held until the next read completes.
- grant  out  1  index of the current or last granted requester.
- busy  out  1  high in every non-IDLE state.
- ram_sel  out  ADDR_W  RAM word select (decodes to the RAM's s0/s1).
- ram_rw  out  1  RAM write strobe: 1 = write, 0 = read.
- ram_wdata  out  DATA_W  RAM write data.
- ram_rdata  in  DATA_W  RAM read data.

Behaviour:
- Clocking and reset: one clock (clk); reset is synchronous and active-low (rst_n).
- Reset values, after any rising edge with rst_n=0:
  - state = IDLE; ack0, ack1, busy, ram_rw = 0.
  - ram_sel, ram_wdata, rdata = 0.
  - grant = 1, so requester 0 wins the first tie.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - req0 and req1 are sampled here only.
  - Exactly one req high: that requester wins.
  - Both high: the requester not equal to grant wins (strict alternation).
  - On a win, register grant, we_r, addr_r and wdata_r from the winner, clear the latency counter, go to ACCESS.
  - No req: stay in IDLE.
- ACCESS:
  - ram_sel = addr_r; ram_wdata = wdata_r.
  - Write: ram_rw = 1 for exactly one cycle, then go to DONE.
  - Read: ram_rw = 0. Count RD_LAT cycles; on the edge ending the last count cycle, capture ram_rdata into rdata and go to DONE.
- DONE:
  - ack[grant] = 1 for exactly one cycle; the other ack stays 0.
  - rdata is stable (written only on read captures).
  - Next state is IDLE.
- Latency from the IDLE sampling edge to ack high:
  - Write: 2 cycles.
  - Read: 1 + RD_LAT cycles (2 at default).
- ram_rw is high only during a write ACCESS cycle; it is 0 in IDLE and DONE, so no spurious RAM write is possible.
- ram_sel and ram_wdata hold their last values outside ACCESS.
- Handshake rules:
  - A requester keeps req, we, addr and wdata stable until it sees ack, then deasserts req on that same edge.
  - A req still high in the IDLE cycle after ack is treated as a new request.
  - A requester's input changes after the IDLE grant edge are ignored; registered values are used.
  - The losing requester's req stays pending and is granted on the next IDLE cycle.
- Back-to-back: with both requesters continuously requesting, grants alternate 0,1,0,1 with one IDLE cycle between transactions.
- Reset mid-operation: any state returns to IDLE at the reset edge. No ack is issued for the aborted transaction, ram_rw drops, and the requester must re-request. A write whose ACCESS cycle coincides with rst_n=0 may or may not have landed in the RAM; software treats it as lost.
- Address wrap: addresses cover 0..3 fully; there is no out-of-range case.

Test Plan:
- Reset then single write: req0=1, we0=1, addr0=2, wdata0=0xA5 → ram_sel=2 and ram_rw=1 for one cycle, ack0 two cycles after grant; ack1 and busy return to 0.
- Read back: req1=1, we1=0, addr1=2 → rdata=0xA5 with ack1 at 1+RD_LAT cycles; repeat with RD_LAT=3 → ack1 at 4 cycles.
- Simultaneous: req0 and req1 both high from reset, writing 0x11@0 and 0x22@1 → grant order 0 then 1, each ack pulses once, and a read of words 0 and 1 returns 0x11 and 0x22.
- Fairness: both req held continuously for 6 transactions → grants alternate 0,1,0,1,0,1 with no starvation.
- Reset mid-read: rst_n=0 during ACCESS of a read of addr 3 → next cycle state IDLE, busy=0, no ack, rdata=0, ram_rw=0; the re-issued read completes normally.
- Write strobe hygiene: monitor asserts ram_rw is never high outside a write ACCESS cycle and never high for 2 consecutive cycles.

Source files
------------

// File: rtl/ram_arbiter_if.sv
// ---------------------------------------------------------------------------
// ram_arbiter_if
// Bundle of every signal between the two requesters, the arbiter and the
// 4-word register-cell RAM.
//
// Handshake (req/ack): a requester raises reqN with weN/addrN/wdataN and
// holds all four stable until it sees ackN high for one cycle; it drops reqN
// on the edge that ends that ack cycle. ackN is a single-cycle pulse. rdata
// is valid while the ack is high and holds until the next read completes.
//
// Signals
//   req0/we0/addr0/wdata0, ack0  : requester 0 (CPU core)
//   req1/we1/addr1/wdata1, ack1  : requester 1 (loader / DMA)
//   rdata                        : captured read data
//   grant                        : index of current / last granted requester
//   busy                         : arbiter is not idle
//   ram_sel/ram_rw/ram_wdata     : RAM word select, write strobe, write data
//   ram_rdata                    : RAM read data
//
// Modports
//   master : requester + RAM side (drives requests and ram_rdata)
//   slave  : the arbiter
// ---------------------------------------------------------------------------
interface ram_arbiter_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2
);

  logic              req0;
  logic              we0;
  logic [ADDR_W-1:0] addr0;
  logic [DATA_W-1:0] wdata0;
  logic              ack0;

  logic              req1;
  logic              we1;
  logic [ADDR_W-1:0] addr1;
  logic [DATA_W-1:0] wdata1;
  logic              ack1;

  logic [DATA_W-1:0] rdata;
  logic              grant;
  logic              busy;

  logic [ADDR_W-1:0] ram_sel;
  logic              ram_rw;
  logic [DATA_W-1:0] ram_wdata;
  logic [DATA_W-1:0] ram_rdata;

  modport master (
    output req0, we0, addr0, wdata0,
    output req1, we1, addr1, wdata1,
    output ram_rdata,
    input  ack0, ack1, rdata, grant, busy,
    input  ram_sel, ram_rw, ram_wdata
  );

  modport slave (
    input  req0, we0, addr0, wdata0,
    input  req1, we1, addr1, wdata1,
    input  ram_rdata,
    output ack0, ack1, rdata, grant, busy,
    output ram_sel, ram_rw, ram_wdata
  );

endinterface

// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
// Two-port round-robin arbiter and access sequencer for the 4-word x 8-bit
// register-cell RAM. Two requesters share the single RAM port through a
// req/ack handshake; the arbiter owns the RAM select, write strobe and write
// data, and returns captured read data.
//
// Ports
//   clk          : system clock, rising edge
//   rst_n        : synchronous active-low reset
//   bus          : ram_arbiter_if.slave (requesters + RAM signals)
//   o_dbg_state  : current FSM state (0 IDLE, 1 ACCESS, 2 DONE)
//
// Parameters
//   DATA_W : RAM word width
//   ADDR_W : RAM address width
//   RD_LAT : cycles ram_sel is held before ram_rdata is captured (1..3)
//
// Transaction timing (counted from the IDLE cycle whose closing edge grants):
//   write : ACCESS 1 cycle, ack visible 2 cycles after the grant edge's cycle
//   read  : ACCESS RD_LAT cycles, ack 1 + RD_LAT cycles after
// ---------------------------------------------------------------------------
module ram_arbiter #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 2,
  parameter int RD_LAT = 1
) (
  input  logic         clk,
  input  logic         rst_n,
  ram_arbiter_if.slave bus,
  output logic [1:0]   o_dbg_state
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  // Two bits cover RD_LAT up to 3 (count runs 0..RD_LAT-1).
  localparam int               CNT_W    = 2;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(RD_LAT - 1);

  state_t            r_state;
  state_t            w_next_state;

  logic              r_grant;
  logic              r_we;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] r_rdata;
  logic [CNT_W-1:0]  r_cnt;

  logic              w_win_valid;
  logic              w_win_idx;
  logic              w_win_we;
  logic [ADDR_W-1:0] w_win_addr;
  logic [DATA_W-1:0] w_win_wdata;
  logic              w_take;
  logic              w_cnt_done;
  logic              w_capture;

  // -------------------------------------------------------------------------
  // Arbitration. On a tie the requester that did not win last time gets the
  // port; grant resets to 1 so requester 0 wins the first tie.
  // -------------------------------------------------------------------------
  always_comb begin
    w_win_valid = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      w_win_idx = ~r_grant;
    end else begin
      w_win_idx = bus.req1;
    end
  end

  always_comb begin
    if (w_win_idx) begin
      w_win_we    = bus.we1;
      w_win_addr  = bus.addr1;
      w_win_wdata = bus.wdata1;
    end else begin
      w_win_we    = bus.we0;
      w_win_addr  = bus.addr0;
      w_win_wdata = bus.wdata0;
    end
  end

  // Requests are sampled only in IDLE; later input changes are ignored
  // because the winner's command is registered at the grant edge.
  assign w_take     = (r_state == S_IDLE) && w_win_valid;
  assign w_cnt_done = (r_cnt == LAST_CNT);
  assign w_capture  = (r_state == S_ACCESS) && !r_we && w_cnt_done;

  // -------------------------------------------------------------------------
  // FSM: state register
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // -------------------------------------------------------------------------
  // FSM: next-state logic
  // -------------------------------------------------------------------------
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_win_valid) begin
          w_next_state = S_ACCESS;
        end
      end
      S_ACCESS: begin
        // A write needs a single strobe cycle; a read waits out RD_LAT.
        if (r_we || w_cnt_done) begin
          w_next_state = S_DONE;
        end
      end
      S_DONE: begin
        w_next_state = S_IDLE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Command / data registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_grant <= 1'b1;
      r_we    <= 1'b0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_cnt   <= '0;
      r_rdata <= '0;
    end else begin
      if (w_take) begin
        r_grant <= w_win_idx;
        r_we    <= w_win_we;
        r_addr  <= w_win_addr;
        r_wdata <= w_win_wdata;
        r_cnt   <= '0;
      end else if ((r_state == S_ACCESS) && !r_we && !w_cnt_done) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

      // rdata changes only on a read capture, so it holds across writes.
      if (w_capture) begin
        r_rdata <= bus.ram_rdata;
      end
    end
  end

  // -------------------------------------------------------------------------
  // FSM: outputs. The write strobe is qualified by ACCESS so it can never be
  // high in IDLE or DONE.
  // -------------------------------------------------------------------------
  always_comb begin
    bus.ack0   = 1'b0;
    bus.ack1   = 1'b0;
    bus.busy   = 1'b0;
    bus.ram_rw = 1'b0;
    case (r_state)
      S_ACCESS: begin
        bus.busy   = 1'b1;
        bus.ram_rw = r_we;
      end
      S_DONE: begin
        bus.busy = 1'b1;
        bus.ack0 = ~r_grant;
        bus.ack1 = r_grant;
      end
      default: begin
        bus.busy = 1'b0;
      end
    endcase
  end

  // Select and write data come straight from the command registers, which
  // only change at a grant edge, so they hold their values outside ACCESS.
  assign bus.ram_sel   = r_addr;
  assign bus.ram_wdata = r_wdata;
  assign bus.rdata     = r_rdata;
  assign bus.grant     = r_grant;
  assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;

  typedef struct packed {
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata;
  } txn_t;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ram_arbiter_if #(.DATA_W(8), .ADDR_W(2)) bus0 ();
  ram_arbiter_if #(.DATA_W(8), .ADDR_W(2)) bus3 ();
  logic [1:0] dbg0;
  logic [1:0] dbg3;

  ram_arbiter #(.DATA_W(8), .ADDR_W(2), .RD_LAT(1)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus0), .o_dbg_state(dbg0)
  );

  ram_arbiter #(.DATA_W(8), .ADDR_W(2), .RD_LAT(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .bus(bus3), .o_dbg_state(dbg3)
  );

  // RAM models (not reset, like the real register cells)
  logic [7:0] mem0 [4];
  logic [7:0] mem3 [4];
  always @(posedge clk) if (bus0.ram_rw) mem0[bus0.ram_sel] <= bus0.ram_wdata;
  always @(posedge clk) if (bus3.ram_rw) mem3[bus3.ram_sel] <= bus3.ram_wdata;
  assign bus0.ram_rdata = mem0[bus0.ram_sel];
  assign bus3.ram_rdata = mem3[bus3.ram_sel];

  // counters
  int checks = 0;
  int errors = 0;

  // reference model state
  logic [7:0] ref_mem [4];
  logic [7:0] ref_mem3 [4];
  int         exp_grant = 1;
  logic [7:0] exp_rd = 8'h00;
  logic [7:0] exp_rd3 = 8'h00;

  // scoreboard queues
  txn_t       q0 [$];
  txn_t       q1 [$];
  int         exp_who [$];
  logic [7:0] exp_q [$];
  logic [9:0] exp_wr [$];
  logic [9:0] wr_obs [$];

  // write strobe monitor
  logic prev_rw = 1'b0;
  int   rw_viol = 0;
  always @(negedge clk) begin
    if (bus0.ram_rw) begin
      wr_obs.push_back({bus0.ram_sel, bus0.ram_wdata});
      if (prev_rw) rw_viol++;
    end
    prev_rw = bus0.ram_rw;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Transaction-level model: who gets each grant, what rdata shows at each ack,
  // and which RAM writes happen, assuming every queued request is pending.
  task automatic build_exp();
    txn_t c0 [$];
    txn_t c1 [$];
    int   g;
    c0 = q0;
    c1 = q1;
    g  = exp_grant;
    exp_who.delete();
    exp_q.delete();
    exp_wr.delete();
    while (c0.size() != 0 || c1.size() != 0) begin
      int   w;
      txn_t t;
      if (c0.size() != 0 && c1.size() != 0) w = 1 - g;
      else w = (c0.size() != 0) ? 0 : 1;
      t = (w == 1) ? c1.pop_front() : c0.pop_front();
      if (t.we) begin
        ref_mem[t.addr] = t.wdata;
        exp_wr.push_back({t.addr, t.wdata});
      end else begin
        exp_rd = ref_mem[t.addr];
      end
      exp_who.push_back(w);
      exp_q.push_back(exp_rd);
      g = w;
    end
    exp_grant = g;
  endtask

  task automatic present(input int r);
    if (r == 0) begin
      if (q0.size() != 0) begin
        bus0.req0 = 1'b1; bus0.we0 = q0[0].we; bus0.addr0 = q0[0].addr; bus0.wdata0 = q0[0].wdata;
      end else bus0.req0 = 1'b0;
    end else begin
      if (q1.size() != 0) begin
        bus0.req1 = 1'b1; bus0.we1 = q1[0].we; bus0.addr1 = q1[0].addr; bus0.wdata1 = q1[0].wdata;
      end else bus0.req1 = 1'b0;
    end
  endtask

  task automatic handle_ack(input int r, input int cyc, inout int k);
    int         w;
    logic [7:0] d;
    if (exp_who.size() == 0) begin
      check("extra_ack", 32'(r + 1), 32'd0);
    end else begin
      w = exp_who.pop_front();
      d = exp_q.pop_front();
      k++;
      check("ack_who", 32'(r), 32'(w));
      check("grant", 32'(bus0.grant), 32'(w));
      check("rdata", 32'(bus0.rdata), 32'(d));
      check("ack_cycle", 32'(cyc), 32'(3 * k - 1));
    end
    if (r == 0 && q0.size() != 0) void'(q0.pop_front());
    if (r == 1 && q1.size() != 0) void'(q1.pop_front());
    present(r);
  endtask

  // Drives q0/q1 on dut (RD_LAT=1); called at posedge+#1 with dut idle.
  task automatic run_txns();
    int cyc = 0;
    int k = 0;
    int max_cyc;
    logic a0, a1;
    build_exp();
    max_cyc = 3 * exp_who.size() + 10;
    wr_obs.delete();
    present(0);
    present(1);
    while (exp_who.size() != 0 && cyc < max_cyc) begin
      @(posedge clk); #1;
      cyc++;
      a0 = bus0.ack0;
      a1 = bus0.ack1;
      if (a0 || a1) check("ack_excl", 32'(a0 & a1), 32'd0);
      if (a0) handle_ack(0, cyc, k);
      if (a1) handle_ack(1, cyc, k);
    end
    check("run_done", 32'(exp_who.size()), 32'd0);
    q0.delete();
    q1.delete();
    bus0.req0 = 1'b0;
    bus0.req1 = 1'b0;
    @(posedge clk); #1;
    check("post_ack0", 32'(bus0.ack0), 32'd0);
    check("post_ack1", 32'(bus0.ack1), 32'd0);
    check("post_busy", 32'(bus0.busy), 32'd0);
    check("wr_count", 32'(wr_obs.size()), 32'(exp_wr.size()));
    for (int i = 0; i < exp_wr.size() && i < wr_obs.size(); i++)
      check("wr_sel_data", 32'(wr_obs[i]), 32'(exp_wr[i]));
  endtask

  // Single transaction on dut3 (RD_LAT=3) through requester 0.
  task automatic txn3(input logic we, input logic [1:0] a, input logic [7:0] d);
    int cyc = 0;
    int exp_lat;
    if (we) begin
      ref_mem3[a] = d;
      exp_lat = 2;
    end else begin
      exp_rd3 = ref_mem3[a];
      exp_lat = 4;
    end
    bus3.req0 = 1'b1; bus3.we0 = we; bus3.addr0 = a; bus3.wdata0 = d;
    while (!bus3.ack0 && cyc < 20) begin
      @(posedge clk); #1;
      cyc++;
    end
    check("l3_latency", 32'(cyc), 32'(exp_lat));
    check("l3_rdata", 32'(bus3.rdata), 32'(exp_rd3));
    bus3.req0 = 1'b0;
    @(posedge clk); #1;
    check("l3_ack_low", 32'(bus3.ack0), 32'd0);
    check("l3_busy_low", 32'(bus3.busy), 32'd0);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    bus0.req0 = 1'b0; bus0.req1 = 1'b0;
    bus3.req0 = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    exp_grant = 1;
    exp_rd    = 8'h00;
    exp_rd3   = 8'h00;
    check("rst_ack0", 32'(bus0.ack0), 32'd0);
    check("rst_ack1", 32'(bus0.ack1), 32'd0);
    check("rst_busy", 32'(bus0.busy), 32'd0);
    check("rst_ram_rw", 32'(bus0.ram_rw), 32'd0);
    check("rst_ram_sel", 32'(bus0.ram_sel), 32'd0);
    check("rst_ram_wdata", 32'(bus0.ram_wdata), 32'd0);
    check("rst_rdata", 32'(bus0.rdata), 32'd0);
    check("rst_grant", 32'(bus0.grant), 32'd1);
    check("rst_state", 32'(dbg0), 32'd0);
    check("rst_rdata3", 32'(bus3.rdata), 32'd0);
    rst_n = 1'b1;
  endtask

  function automatic txn_t rand_txn();
    txn_t t;
    t.we    = 1'($urandom_range(0, 1));
    t.addr  = 2'($urandom_range(0, 3));
    t.wdata = 8'($urandom_range(0, 255));
    return t;
  endfunction

  initial begin
    for (int i = 0; i < 4; i++) begin
      ref_mem[i]  = 8'h00;
      ref_mem3[i] = 8'h00;
    end
    bus0.req0 = 1'b0; bus0.we0 = 1'b0; bus0.addr0 = 2'd0; bus0.wdata0 = 8'h00;
    bus0.req1 = 1'b0; bus0.we1 = 1'b0; bus0.addr1 = 2'd0; bus0.wdata1 = 8'h00;
    bus3.req0 = 1'b0; bus3.we0 = 1'b0; bus3.addr0 = 2'd0; bus3.wdata0 = 8'h00;
    bus3.req1 = 1'b0; bus3.we1 = 1'b0; bus3.addr1 = 2'd0; bus3.wdata1 = 8'h00;

    // reset values
    do_reset();

    // single write by requester 0, then read back by requester 1
    q0.push_back('{we: 1'b1, addr: 2'd2, wdata: 8'hA5});
    run_txns();
    q1.push_back('{we: 1'b0, addr: 2'd2, wdata: 8'h00});
    run_txns();

    // fill the remaining words so later reads have known contents
    q0.push_back('{we: 1'b1, addr: 2'd0, wdata: 8'($urandom_range(0, 255))});
    q0.push_back('{we: 1'b1, addr: 2'd1, wdata: 8'($urandom_range(0, 255))});
    q0.push_back('{we: 1'b1, addr: 2'd3, wdata: 8'($urandom_range(0, 255))});
    run_txns();

    // RD_LAT=3 instance: write then read back, plus a random pair
    txn3(1'b1, 2'd2, 8'hA5);
    txn3(1'b0, 2'd2, 8'h00);
    for (int i = 0; i < 3; i++) txn3(1'b1, 2'(i == 2 ? 3 : i), 8'($urandom_range(0, 255)));
    txn3(1'b0, 2'($urandom_range(0, 3)), 8'h00);
    txn3(1'b0, 2'($urandom_range(0, 3)), 8'h00);

    // simultaneous requests straight out of reset
    do_reset();
    q0.push_back('{we: 1'b1, addr: 2'd0, wdata: 8'h11});
    q1.push_back('{we: 1'b1, addr: 2'd1, wdata: 8'h22});
    run_txns();
    q0.push_back('{we: 1'b0, addr: 2'd0, wdata: 8'h00});
    q1.push_back('{we: 1'b0, addr: 2'd1, wdata: 8'h00});
    run_txns();

    // fairness: both requesters hold req for 3 transactions each
    for (int i = 0; i < 3; i++) begin
      q0.push_back(rand_txn());
      q1.push_back(rand_txn());
    end
    run_txns();

    // random rounds with uneven queue depths
    for (int r = 0; r < 6; r++) begin
      int n0 = $urandom_range(0, 3);
      int n1 = $urandom_range(1, 3);
      for (int i = 0; i < n0; i++) q0.push_back(rand_txn());
      for (int i = 0; i < n1; i++) q1.push_back(rand_txn());
      run_txns();
    end

    // reset in the middle of a read of word 3
    bus0.req0 = 1'b1; bus0.we0 = 1'b0; bus0.addr0 = 2'd3;
    @(posedge clk); #1;
    check("mr_busy_pre", 32'(bus0.busy), 32'd1);
    rst_n = 1'b0;
    bus0.req0 = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    exp_grant = 1;
    exp_rd    = 8'h00;
    exp_rd3   = 8'h00;
    check("mr_state", 32'(dbg0), 32'd0);
    check("mr_busy", 32'(bus0.busy), 32'd0);
    check("mr_ack0", 32'(bus0.ack0), 32'd0);
    check("mr_ack1", 32'(bus0.ack1), 32'd0);
    check("mr_rdata", 32'(bus0.rdata), 32'd0);
    check("mr_ram_rw", 32'(bus0.ram_rw), 32'd0);
    check("mr_grant", 32'(bus0.grant), 32'd1);
    q0.push_back('{we: 1'b0, addr: 2'd3, wdata: 8'h00});
    run_txns();

    check("rw_consecutive", 32'(rw_viol), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
